// File: rtl/camera_init_ctrl.sv
// Camera mode controller: a one_flag/two_flag request selects the frame geometry and re-initialises the camera.
// Optional CAMINIT_PWRUP_RST_EN: issue one mode-1 reset pulse and settle window right after reset release.
module camera_init_ctrl #(
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned WAIT_CYCLES = 64,
  parameter int unsigned MODE1_X     = 640,
  parameter int unsigned MODE1_Y     = 480,
  parameter int unsigned MODE2_X     = 1280,
  parameter int unsigned MODE2_Y     = 720
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        one_flag,
  input  logic        two_flag,
  output logic        camera_rstn,
  output logic [15:0] x_lenth,
  output logic [15:0] y_lenth,
  output logic        mode,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RST_LOW, SETTLE} state_t;

  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rstn_q, rstn_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        mode_q, mode_d;
  logic        busy_q, busy_d;
  logic        req, tgt;
  logic        start;

`ifdef CAMINIT_PWRUP_RST_EN
  logic pwrup_q, pwrup_d;
`endif

  // two_flag has priority when both are raised together
  assign req = one_flag | two_flag;
  assign tgt = two_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rstn_q  <= 1'b1;
      x_q     <= 16'(MODE1_X);
      y_q     <= 16'(MODE1_Y);
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CAMINIT_PWRUP_RST_EN
      pwrup_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rstn_q  <= rstn_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
`ifdef CAMINIT_PWRUP_RST_EN
      pwrup_q <= pwrup_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rstn_d  = rstn_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    start   = 1'b0;
`ifdef CAMINIT_PWRUP_RST_EN
    pwrup_d = pwrup_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef CAMINIT_PWRUP_RST_EN
        if (pwrup_q) begin
          start   = 1'b1;
          mode_d  = 1'b0;
          pwrup_d = 1'b0;
        end else
`endif
        if (req && (tgt != mode_q)) begin
          start  = 1'b1;
          mode_d = tgt;
        end
        // geometry only ever changes on entry to RST_LOW
        if (start) begin
          state_d = RST_LOW;
          cnt_d   = '0;
          rstn_d  = 1'b0;
          busy_d  = 1'b1;
          x_d     = mode_d ? 16'(MODE2_X) : 16'(MODE1_X);
          y_d     = mode_d ? 16'(MODE2_Y) : 16'(MODE1_Y);
        end
      end
      RST_LOW: begin
        if (cnt_q == RST_LAST) begin
          state_d = SETTLE;
          cnt_d   = '0;
          rstn_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rstn_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign camera_rstn = rstn_q;
  assign x_lenth     = x_q;
  assign y_lenth     = y_q;
  assign mode        = mode_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_camera_init_ctrl.sv
// Bench for camera_init_ctrl: sequence-level model checked every cycle plus directed literal checks.
module tb_camera_init_ctrl;

  localparam int RST = 16;
  localparam int WT  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        one_flag = 1'b0;
  logic        two_flag = 1'b0;
  logic        camera_rstn;
  logic [15:0] x_lenth, y_lenth;
  logic        mode, busy;

  int n_checks = 0;
  int n_fail   = 0;

  camera_init_ctrl #(
    .RST_CYCLES(RST), .WAIT_CYCLES(WT),
    .MODE1_X(640), .MODE1_Y(480), .MODE2_X(1280), .MODE2_Y(720)
  ) dut (
    .clk(clk), .rst(rst), .one_flag(one_flag), .two_flag(two_flag),
    .camera_rstn(camera_rstn), .x_lenth(x_lenth), .y_lenth(y_lenth),
    .mode(mode), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is "elapsed" clocks old; rstn low for the first RST, busy for RST+WT.
  bit m_active = 0;
  int m_el     = 0;
  bit m_mode   = 0;
`ifdef CAMINIT_PWRUP_RST_EN
  bit m_pend   = 1;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_el = 0; m_mode = 0;
`ifdef CAMINIT_PWRUP_RST_EN
      m_pend = 1;
`endif
    end else if (m_active) begin
      m_el++;
      if (m_el == RST + WT) m_active = 0;
    end else begin
`ifdef CAMINIT_PWRUP_RST_EN
      if (m_pend) begin
        m_pend = 0; m_active = 1; m_el = 0; m_mode = 0;
      end else
`endif
      if ((one_flag || two_flag) && (two_flag != m_mode)) begin
        m_active = 1; m_el = 0; m_mode = two_flag;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_rstn", int'(camera_rstn), (m_active && m_el < RST) ? 0 : 1);
      chk("cyc_busy", int'(busy), int'(m_active));
      chk("cyc_mode", int'(mode), int'(m_mode));
      chk("cyc_x", int'(x_lenth), m_mode ? 1280 : 640);
      chk("cyc_y", int'(y_lenth), m_mode ? 720 : 480);
    end
  end

  // Drive a request for one clock, then count low/busy cycles of the resulting sequence.
  task automatic run_seq(input bit o, input bit t, input int inj_at,
                         input int exp_low, input int exp_busy, input string tag);
    int low, bcnt;
    bit done;
    low = 0; bcnt = 0; done = 0;
    @(negedge clk); one_flag = o; two_flag = t;
    @(negedge clk); one_flag = 0; two_flag = 0;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) @(negedge clk);
      one_flag = (i == inj_at) || (i == inj_at + 30);
      two_flag = (i == inj_at) || (i == inj_at + 30);
      if (!busy) begin done = 1; break; end
      bcnt++;
      if (!camera_rstn) low++;
    end
    one_flag = 0; two_flag = 0;
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_low"}, low, exp_low);
    chk({tag, "_busy"}, bcnt, exp_busy);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
`ifdef CAMINIT_PWRUP_RST_EN
    @(negedge clk);
    chk("pwrup_low", int'(camera_rstn), 0);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    chk("pwrup_end", int'(busy), 0);
`endif
    repeat (100) @(negedge clk);
    chk("idle_rstn", int'(camera_rstn), 1);
    chk("idle_x", int'(x_lenth), 640);
    chk("idle_y", int'(y_lenth), 480);
    chk("idle_busy", int'(busy), 0);
    chk("idle_mode", int'(mode), 0);

    run_seq(0, 1, -1, 16, 80, "m2");
    chk("m2_x", int'(x_lenth), 1280);
    chk("m2_y", int'(y_lenth), 720);
    chk("m2_mode", int'(mode), 1);

    run_seq(1, 0, -1, 16, 80, "m1");
    chk("m1_x", int'(x_lenth), 640);
    chk("m1_y", int'(y_lenth), 480);
    repeat (5) @(negedge clk);
    run_seq(1, 0, -1, 0, 0, "same");
    chk("same_x", int'(x_lenth), 640);

    run_seq(1, 1, -1, 16, 80, "both");
    chk("both_x", int'(x_lenth), 1280);
    chk("both_mode", int'(mode), 1);

    // requests injected mid-sequence (during RST_LOW and SETTLE) must be dropped
    run_seq(1, 0, 5, 16, 80, "drop");
    chk("drop_mode", int'(mode), 0);
    chk("drop_x", int'(x_lenth), 640);
    repeat (10) @(negedge clk);

    @(negedge clk); two_flag = 1;
    @(negedge clk); two_flag = 0;
    repeat (4) @(negedge clk);
    chk("mid_low", int'(camera_rstn), 0);
    #2 rst = 1;
    #1;
    chk("arst_rstn", int'(camera_rstn), 1);
    chk("arst_x", int'(x_lenth), 640);
    chk("arst_busy", int'(busy), 0);
    chk("arst_mode", int'(mode), 0);
    @(negedge clk); rst = 0;
    @(negedge clk);
`ifdef CAMINIT_PWRUP_RST_EN
    chk("rel_rstn", int'(camera_rstn), 0);
`else
    chk("rel_rstn", int'(camera_rstn), 1);
`endif
    repeat (100) @(negedge clk);
    chk("final_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
